// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU logic datapath: op codes, FSM states and
// the elaboration-time parameter legality check.
package alu_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Also used by the arithmetic unit, which shares the slice-serial scheme.
  function automatic bit params_legal(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/logic_slice.sv
// One SLICE-bit slice of the logic unit; purely combinational, shared by
// every slice position through the top-level index mux.
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  // Op-code decode for one slice.
  always_comb begin
    y = {SLICE{1'b0}};
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = {SLICE{1'b0}};
    endcase
  end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Slice-serial bitwise logic unit: operands are captured once, then one
// SLICE-bit slice is processed per cycle; zero/parity flags go with the result.
module bitwise_logic_seq
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (!params_legal(WIDTH, SLICE)) begin : g_param_check
    $error("bitwise_logic_seq: WIDTH must be a positive multiple of SLICE");
  end

  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] res_r;
  logic             zero_r;
  logic             parity_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] b_sl_s;
  logic [SLICE-1:0] y_sl_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // Select the operand slice addressed by the slice index.
  always_comb begin
    a_sl_s = {SLICE{1'b0}};
    b_sl_s = {SLICE{1'b0}};
    for (int i = 0; i < NSLICE; i++) begin
      a_sl_s = (idx_r == IDXW'(i)) ? a_r[i*SLICE +: SLICE] : a_sl_s;
      b_sl_s = (idx_r == IDXW'(i)) ? b_r[i*SLICE +: SLICE] : b_sl_s;
    end
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op (op_r),
    .a  (a_sl_s),
    .b  (b_sl_s),
    .y  (y_sl_s)
  );

  // Merge the freshly computed slice into the result; flags on the last
  // slice are taken from this merged value so they cover the whole word.
  always_comb begin
    res_next_s = res_r;
    for (int i = 0; i < NSLICE; i++) begin
      res_next_s[i*SLICE +: SLICE] = (idx_r == IDXW'(i)) ? y_sl_s
                                                          : res_r[i*SLICE +: SLICE];
    end
    last_s = (idx_r == IDXW'(NSLICE - 1));
  end

  // Control FSM, operand capture and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 3'd0;
      idx_r       <= {IDXW{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      parity_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            op_r       <= op;
            idx_r      <= {IDXW{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_r <= res_next_s;
          idx_r <= idx_r + IDXW'(1'b1);
          if (last_s) begin
            zero_r      <= (res_next_s == {WIDTH{1'b0}});
            parity_r    <= parity_f(res_next_s);
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = res_r;
  assign zero      = zero_r;
  assign parity    = parity_r;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Self-checking bench: directed cases plus randomized requests on an 8/4 and
// a 16/4 instance, compared against a whole-word reference model.
module tb_bitwise_logic_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, result8;
  logic        zero8, parity8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000, result16;
  logic        zero16, parity16;
  int          last_acc16 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitwise_logic_seq #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .parity(parity8)
  );

  bitwise_logic_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .zero(zero16), .parity(parity16)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x ^ y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start8(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
    int w = 0;
    while (!in_ready8 && w < 20) begin @(negedge clk); w++; end
    chk("in_ready8_before_accept", in_ready8, 1'b1);
    in_valid8 = 1'b1; op8 = o; a8 = xa; b8 = xb;
    @(negedge clk);
    in_valid8 = 1'b0;
    op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic finish8(input logic [7:0] exp, input int stall);
    int lat = 0;
    if (stall > 0) out_ready8 = 1'b0;
    while (!out_valid8 && lat < 20) begin @(negedge clk); lat++; end
    chk("latency8", 16'(lat), 16'd2);
    chk("result8", result8, exp);
    chk("zero8", zero8, exp == 8'h00);
    chk("parity8", parity8, ^exp);
    chk("in_ready8_busy", in_ready8, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid8", out_valid8, 1'b1);
      chk("stall_result8", result8, exp);
      chk("stall_in_ready8", in_ready8, 1'b0);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    chk("handoff_valid8", out_valid8, 1'b0);
    chk("handoff_in_ready8", in_ready8, 1'b1);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                      input int stall);
    logic [15:0] m;
    m = model(o, {8'h00, xa}, {8'h00, xb});
    start8(o, xa, xb);
    finish8(m[7:0], stall);
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] xa, input logic [15:0] xb,
                       input int stall);
    logic [15:0] exp;
    int w = 0;
    exp = model(o, xa, xb);
    while (!in_ready16 && w < 20) begin @(negedge clk); w++; end
    chk("in_ready16_before_accept", in_ready16, 1'b1);
    in_valid16 = 1'b1; op16 = o; a16 = xa; b16 = xb;
    @(negedge clk);
    last_acc16 = cyc;
    in_valid16 = 1'b0;
    op16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    if (stall > 0) out_ready16 = 1'b0;
    w = 0;
    while (!out_valid16 && w < 20) begin @(negedge clk); w++; end
    chk("latency16", 16'(w), 16'd4);
    chk("result16", result16, exp);
    chk("zero16", zero16, exp == 16'h0000);
    chk("parity16", parity16, ^exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_result16", result16, exp);
    end
    out_ready16 = 1'b1;
    @(negedge clk);
    chk("handoff_valid16", out_valid16, 1'b0);
  endtask

  initial begin
    int prev_acc;
    logic [15:0] ra, rb;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready8", in_ready8, 1'b1);
    chk("rst_out_valid8", out_valid8, 1'b0);
    chk("rst_result8", result8, 8'h00);
    chk("rst_zero8", zero8, 1'b0);
    chk("rst_parity8", parity8, 1'b0);
    chk("rst_in_ready16", in_ready16, 1'b1);

    // Directed cases on the 8/4 instance.
    start8(3'd2, 8'hA5, 8'h3C); finish8(8'h99, 0);
    start8(3'd4, 8'hFF, 8'hFF); finish8(8'h00, 0);
    start8(3'd6, 8'h0F, 8'hAA); finish8(8'hF0, 0);
    start8(3'd3, 8'h00, 8'h01); finish8(8'hFE, 5);
    start8(3'd0, 8'hF0, 8'h3C); a8 = 8'h00; finish8(8'h30, 0);

    // Reset in the middle of RUN discards the partial result.
    start8(3'd1, 8'hFF, 8'h00);
    pulse_reset();
    chk("midrun_rst_valid", out_valid8, 1'b0);
    chk("midrun_rst_in_ready", in_ready8, 1'b1);
    chk("midrun_rst_result", result8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrun_rst_no_output", out_valid8, 1'b0);
    end
    run8(3'd1, 8'h11, 8'h22, 0);

    // Reset while DONE is stalled clears the flags too.
    out_ready8 = 1'b0;
    start8(3'd4, 8'hFF, 8'hFF);
    @(negedge clk); @(negedge clk);
    chk("done_wait_valid", out_valid8, 1'b1);
    chk("done_wait_zero", zero8, 1'b1);
    pulse_reset();
    out_ready8 = 1'b1;
    chk("done_rst_valid", out_valid8, 1'b0);
    chk("done_rst_zero", zero8, 1'b0);
    chk("done_rst_in_ready", in_ready8, 1'b1);

    // 16/4 instance: latency 4 and one accept every 6 cycles.
    run16(3'd0, 16'hFFFF, 16'h1234, 0);
    prev_acc = last_acc16;
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run16(3'($urandom), ra, rb, 0);
      chk("throughput16", 16'(last_acc16 - prev_acc), 16'd6);
      prev_acc = last_acc16;
    end

    // Randomized traffic on both instances.
    for (int k = 0; k < 40; k++) begin
      run8(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < 15; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run16(3'($urandom), ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
